// File: rtl/audio_dsp_scheduler.sv
// Audio DSP scheduler: captures L/R codec samples on LR clock edges, time-shares one filter
// engine over a req/ack handshake, applies saturating master volume and drives the output regs.
module audio_dsp_scheduler #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned VOL_DEFAULT = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        lrck,
  input  logic [15:0] audio_inL,
  input  logic [15:0] audio_inR,
  input  logic        DSP_enable,
  input  logic [3:0]  filter_select,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        dsp_ack,
  input  logic [15:0] dsp_dout,
  output logic        dsp_req,
  output logic        dsp_chan,
  output logic [3:0]  dsp_sel,
  output logic [15:0] dsp_din,
  output logic [15:0] audio_outL,
  output logic [15:0] audio_outR,
  output logic [3:0]  volume,
  output logic        overrun,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StScale, StWrite} state_e;

  state_e state_q, state_d;

  // Bit 0 = lrck, bit 1 = vol_up, bit 2 = vol_down
  logic [2:0] sync_meta_q, sync_q, sync_prev_q;
  logic       lrck_rise, lrck_fall, up_rise, dn_rise;

  logic [15:0]       slot_l_q, slot_l_d, slot_r_q, slot_r_d;
  logic              pend_l_q, pend_l_d, pend_r_q, pend_r_d;
  logic [15:0]       work_q, work_d, scaled_q, scaled_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              chan_q, chan_d, req_q, req_d;
  logic [3:0]        sel_q, sel_d, vol_q, vol_d;
  logic [15:0]       din_q, din_d, out_l_q, out_l_d, out_r_q, out_r_d;
  logic              overrun_q, overrun_d, timeout_q, timeout_d;
  logic              disp_l, disp_r;

  logic signed [20:0] work_ext, gain_ext, prod, shifted;
  logic        [15:0] sat;

  assign lrck_rise = sync_q[0] & ~sync_prev_q[0];
  assign lrck_fall = ~sync_q[0] & sync_prev_q[0];
  assign up_rise   = sync_q[1] & ~sync_prev_q[1];
  assign dn_rise   = sync_q[2] & ~sync_prev_q[2];

  // Gain is unsigned 0..15 with 3 fractional bits, so 8 is unity
  assign work_ext = {{5{work_q[15]}}, work_q};
  assign gain_ext = {17'd0, vol_q};
  assign prod     = work_ext * gain_ext;
  assign shifted  = prod >>> 3;

  // Clamp the scaled product into the 16-bit signed range
  always_comb begin
    sat = shifted[15:0];
    if (shifted > 21'sd32767) begin
      sat = 16'h7FFF;
    end else if (shifted < -21'sd32768) begin
      sat = 16'h8000;
    end
  end

  assign disp_l = (state_q == StIdle) && pend_l_q;
  assign disp_r = (state_q == StIdle) && !pend_l_q && pend_r_q;

  // Next-state, capture, dispatch and volume logic
  always_comb begin
    state_d   = state_q;
    slot_l_d  = slot_l_q;
    slot_r_d  = slot_r_q;
    pend_l_d  = pend_l_q;
    pend_r_d  = pend_r_q;
    work_d    = work_q;
    scaled_d  = scaled_q;
    timer_d   = timer_q;
    chan_d    = chan_q;
    req_d     = req_q;
    sel_d     = sel_q;
    din_d     = din_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    vol_d     = vol_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;

    // Dispatch clears the flag first so a same-cycle capture re-arms it without an overrun
    if (disp_l) pend_l_d = 1'b0;
    if (disp_r) pend_r_d = 1'b0;

    if (lrck_rise) begin
      slot_l_d = audio_inL;
      pend_l_d = 1'b1;
      if (pend_l_q && !disp_l) overrun_d = 1'b1;
    end
    if (lrck_fall) begin
      slot_r_d = audio_inR;
      pend_r_d = 1'b1;
      if (pend_r_q && !disp_r) overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (disp_l || disp_r) begin
          chan_d  = disp_r;
          din_d   = disp_r ? slot_r_q : slot_l_q;
          work_d  = disp_r ? slot_r_q : slot_l_q;
          sel_d   = filter_select;
          state_d = DSP_enable ? StIssue : StScale;
        end
      end
      StIssue: begin
        req_d   = 1'b1;
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (dsp_ack) begin
          work_d  = dsp_dout;
          req_d   = 1'b0;
          state_d = StScale;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = StScale;
        end
      end
      StScale: begin
        scaled_d = sat;
        state_d  = StWrite;
      end
      StWrite: begin
        if (chan_q) out_r_d = scaled_q;
        else        out_l_d = scaled_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (up_rise && !dn_rise && vol_q != 4'd15) begin
      vol_d = vol_q + 4'd1;
    end else if (dn_rise && !up_rise && vol_q != 4'd0) begin
      vol_d = vol_q - 4'd1;
    end
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Synchronizers and edge-detector history
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      sync_prev_q <= '0;
    end else begin
      sync_meta_q <= {vol_down, vol_up, lrck};
      sync_q      <= sync_meta_q;
      sync_prev_q <= sync_q;
    end
  end

  // Datapath and status registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slot_l_q  <= '0;
      slot_r_q  <= '0;
      pend_l_q  <= 1'b0;
      pend_r_q  <= 1'b0;
      work_q    <= '0;
      scaled_q  <= '0;
      timer_q   <= '0;
      chan_q    <= 1'b0;
      req_q     <= 1'b0;
      sel_q     <= '0;
      din_q     <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      vol_q     <= 4'(VOL_DEFAULT);
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      slot_l_q  <= slot_l_d;
      slot_r_q  <= slot_r_d;
      pend_l_q  <= pend_l_d;
      pend_r_q  <= pend_r_d;
      work_q    <= work_d;
      scaled_q  <= scaled_d;
      timer_q   <= timer_d;
      chan_q    <= chan_d;
      req_q     <= req_d;
      sel_q     <= sel_d;
      din_q     <= din_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      vol_q     <= vol_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign dsp_req    = req_q;
  assign dsp_chan   = chan_q;
  assign dsp_sel    = sel_q;
  assign dsp_din    = din_q;
  assign audio_outL = out_l_q;
  assign audio_outR = out_r_q;
  assign volume     = vol_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign busy       = (state_q != StIdle);

endmodule
